// File: rtl/dfd_trace_mem_sink_ctrl.sv
// ============================================================================
// Module   : dfd_trace_mem_sink_ctrl (+ generic_mem_model bank)
// Brief    : Banked trace SRAM sink with a circular/stop write pointer and a
//            1-cycle debug readback port that yields to trace writes per bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module generic_mem_model #(
    parameter int ADDR_WIDTH        = 9,
    parameter int DATA_WIDTH        = 64,
    parameter int TSEL_CONFIGURABLE = 0
) (
    input  logic                  clk,
    input  logic                  chip_en_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  wr_all_i,
    input  logic                  repair_i,
    input  logic [DATA_WIDTH-1:0] wr_mask_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [10:0]           tsel_settings_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  w_unused;

    // Timing-select and repair controls have no behavioural effect in the model.
    assign w_unused = ^{rd_en_i, wr_all_i, repair_i, tsel_settings_i,
                        (TSEL_CONFIGURABLE != 0)};

    always_ff @(posedge clk) begin
        if (chip_en_i) begin
            if (wr_en_i) begin
                mem_q[addr_i] <= (mem_q[addr_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);
            end else begin
                rd_data_q <= mem_q[addr_i];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

module dfd_trace_mem_sink_ctrl #(
    parameter int NUM_BANKS         = 8,
    parameter int INDEX_WIDTH       = 9,
    parameter int DATA_WIDTH        = 64,
    parameter int TSEL_CONFIGURABLE = 0,
    localparam int c_BW             = $clog2(NUM_BANKS),
    localparam int c_AW             = c_BW + INDEX_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_enable,
    input  logic                  i_mode_stop,
    input  logic                  i_clear,
    input  logic                  i_trc_valid,
    input  logic [DATA_WIDTH-1:0] i_trc_data,
    output logic                  o_trc_ready,
    output logic [c_AW-1:0]       o_wr_ptr,
    output logic                  o_wrapped,
    output logic                  o_full,
    input  logic                  i_rd_req,
    input  logic [c_AW-1:0]       i_rd_addr,
    output logic                  o_rd_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic [10:0]           i_mem_tsel_settings
);

    localparam logic [c_AW-1:0] c_LAST_ENTRY = '1;

    logic [c_AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic                  wrapped_q, wrapped_d;
    logic                  full_q, full_d;
    logic                  rd_valid_q;
    logic [c_BW-1:0]       rd_bank_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  w_trc_ready;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic [c_BW-1:0]       w_wr_bank;
    logic [c_BW-1:0]       w_rd_bank;
    logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_wr_bank   = wr_ptr_q[c_BW-1:0];
    assign w_rd_bank   = i_rd_addr[c_BW-1:0];
    assign w_trc_ready = i_enable & ~i_clear & ~(i_mode_stop & full_q);
    assign w_wr_fire   = i_trc_valid & w_trc_ready;
    // Trace capture never stalls: a read colliding on the write bank waits.
    assign w_rd_fire   = i_rd_req & ~(w_wr_fire & (w_wr_bank == w_rd_bank));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wrapped_d = wrapped_q;
        full_d    = full_q;
        if (i_clear) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
            full_d    = 1'b0;
        end else if (w_wr_fire) begin
            wr_ptr_d = wr_ptr_q + c_AW'(1);
            if (wr_ptr_q == c_LAST_ENTRY) begin
                wrapped_d = 1'b1;
                full_d    = full_q | i_mode_stop;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            wrapped_q  <= 1'b0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wrapped_q  <= wrapped_d;
            full_q     <= full_d;
            rd_valid_q <= w_rd_fire;
            if (w_rd_fire) begin
                rd_bank_q <= w_rd_bank;
            end
            if (rd_valid_q) begin
                rd_data_q <= w_rd_mux;
            end
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic                   w_wr_sel;
            logic                   w_rd_sel;
            logic [INDEX_WIDTH-1:0] w_addr;

            assign w_wr_sel = w_wr_fire & (w_wr_bank == c_BW'(b));
            assign w_rd_sel = w_rd_fire & (w_rd_bank == c_BW'(b));
            assign w_addr   = w_wr_sel ? wr_ptr_q[c_AW-1:c_BW] : i_rd_addr[c_AW-1:c_BW];

            generic_mem_model #(
                .ADDR_WIDTH        (INDEX_WIDTH),
                .DATA_WIDTH        (DATA_WIDTH),
                .TSEL_CONFIGURABLE (TSEL_CONFIGURABLE)
            ) u_mem (
                .clk             (clk),
                .chip_en_i       (w_wr_sel | w_rd_sel),
                .wr_en_i         (w_wr_sel),
                .rd_en_i         (1'b0),
                .wr_all_i        (1'b0),
                .repair_i        (1'b0),
                .wr_mask_i       ({DATA_WIDTH{1'b1}}),
                .addr_i          (w_addr),
                .wr_data_i       (i_trc_data),
                .tsel_settings_i (i_mem_tsel_settings),
                .rd_data_o       (w_bank_rdata[b])
            );
        end
    endgenerate

    // Live bank output during the valid cycle, then a held copy afterwards.
    assign w_rd_mux    = w_bank_rdata[rd_bank_q];
    assign o_rd_data   = rd_valid_q ? w_rd_mux : rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_trc_ready = w_trc_ready;
    assign o_rd_ready  = w_rd_fire;
    assign o_wr_ptr    = wr_ptr_q;
    assign o_wrapped   = wrapped_q;
    assign o_full      = full_q;

endmodule

`default_nettype wire

// File: tb/tb_dfd_trace_mem_sink_ctrl.sv
// ============================================================================
// Module   : tb_dfd_trace_mem_sink_ctrl
// Brief    : Vector table, async-reset sequence and random traffic vs a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dfd_trace_mem_sink_ctrl;

    localparam int NB  = 2;
    localparam int ENT = 8;

    typedef struct {
        logic        en, stop, clr, valid;
        logic [15:0] d;
        logic        rq;
        logic [2:0]  ra;
        logic        x_trdy, x_rrdy;
        logic [2:0]  x_ptr;
        logic        x_wrap, x_full, x_rv;
        logic [15:0] x_rdata;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        i_enable, i_mode_stop, i_clear, i_trc_valid;
    logic [15:0] i_trc_data;
    logic        o_trc_ready;
    logic [2:0]  o_wr_ptr;
    logic        o_wrapped, o_full;
    logic        i_rd_req;
    logic [2:0]  i_rd_addr;
    logic        o_rd_ready, o_rd_valid;
    logic [15:0] o_rd_data;
    logic [10:0] i_mem_tsel_settings;

    dfd_trace_mem_sink_ctrl #(
        .NUM_BANKS(2), .INDEX_WIDTH(2), .DATA_WIDTH(16), .TSEL_CONFIGURABLE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_mode_stop(i_mode_stop),
        .i_clear(i_clear), .i_trc_valid(i_trc_valid), .i_trc_data(i_trc_data),
        .o_trc_ready(o_trc_ready), .o_wr_ptr(o_wr_ptr), .o_wrapped(o_wrapped),
        .o_full(o_full), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .o_rd_ready(o_rd_ready), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .i_mem_tsel_settings(i_mem_tsel_settings)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: flat entry array plus pointer/flags as plain integers.
    logic [15:0] m_mem [ENT];
    bit          m_known [ENT];
    int          m_ptr;
    bit          m_wrapped, m_full, m_rv, m_rdknown, m_last_rf;
    logic [15:0] m_rdata;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) m_known[i] = 1'b0;
        m_ptr = 0; m_wrapped = 0; m_full = 0; m_rv = 0;
        m_rdata = '0; m_rdknown = 1; m_last_rf = 0;
    endtask

    function automatic vec_t mk(logic en, logic stop, logic clr, logic valid, logic [15:0] d,
                                logic rq, logic [2:0] ra, logic tr, logic rr, logic [2:0] p,
                                logic w, logic f, logic rv, logic [15:0] rd);
        vec_t v;
        v.en = en; v.stop = stop; v.clr = clr; v.valid = valid; v.d = d;
        v.rq = rq; v.ra = ra; v.x_trdy = tr; v.x_rrdy = rr; v.x_ptr = p;
        v.x_wrap = w; v.x_full = f; v.x_rv = rv; v.x_rdata = rd;
        return v;
    endfunction

    // One clock: drive, check handshakes, advance model across the edge, check state.
    task automatic cyc(input vec_t v, input bit use_exp, input string tag);
        bit rdy, wf, rf;
        i_enable = v.en; i_mode_stop = v.stop; i_clear = v.clr; i_trc_valid = v.valid;
        i_trc_data = v.d; i_rd_req = v.rq; i_rd_addr = v.ra;
        #1;
        rdy = v.en && !v.clr && !(v.stop && m_full);
        wf  = v.valid && rdy;
        rf  = v.rq && !(wf && ((m_ptr % NB) == (int'(v.ra) % NB)));
        chk({tag, ".trc_ready"}, 32'(o_trc_ready), 32'(rdy));
        chk({tag, ".rd_ready"}, 32'(o_rd_ready), 32'(rf));
        if (use_exp) begin
            chk({tag, ".tbl_trc_ready"}, 32'(o_trc_ready), 32'(v.x_trdy));
            chk({tag, ".tbl_rd_ready"}, 32'(o_rd_ready), 32'(v.x_rrdy));
        end
        @(posedge clk);
        m_rv = rf;
        if (rf) begin
            m_rdata   = m_mem[v.ra];
            m_rdknown = m_known[v.ra];
        end
        if (wf) begin
            m_mem[m_ptr]   = v.d;
            m_known[m_ptr] = 1'b1;
        end
        if (v.clr) begin
            m_ptr = 0; m_wrapped = 0; m_full = 0;
        end else if (wf) begin
            if (m_ptr == ENT - 1) begin
                m_wrapped = 1;
                if (v.stop) m_full = 1;
            end
            m_ptr = (m_ptr + 1) % ENT;
        end
        m_last_rf = rf;
        #1;
        chk({tag, ".wr_ptr"}, 32'(o_wr_ptr), 32'(m_ptr));
        chk({tag, ".wrapped"}, 32'(o_wrapped), 32'(m_wrapped));
        chk({tag, ".full"}, 32'(o_full), 32'(m_full));
        chk({tag, ".rd_valid"}, 32'(o_rd_valid), 32'(m_rv));
        if (m_rdknown) chk({tag, ".rd_data"}, 32'(o_rd_data), 32'(m_rdata));
        if (use_exp) begin
            chk({tag, ".tbl_wr_ptr"}, 32'(o_wr_ptr), 32'(v.x_ptr));
            chk({tag, ".tbl_wrapped"}, 32'(o_wrapped), 32'(v.x_wrap));
            chk({tag, ".tbl_full"}, 32'(o_full), 32'(v.x_full));
            chk({tag, ".tbl_rd_valid"}, 32'(o_rd_valid), 32'(v.x_rv));
            chk({tag, ".tbl_rd_data"}, 32'(o_rd_data), 32'(v.x_rdata));
        end
    endtask

    initial begin
        vec_t v;
        bit   hold;
        logic [2:0] haddr;

        reset_n = 1'b0;
        i_enable = 0; i_mode_stop = 0; i_clear = 0; i_trc_valid = 0; i_trc_data = '0;
        i_rd_req = 0; i_rd_addr = '0; i_mem_tsel_settings = 11'h2A5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.wr_ptr", 32'(o_wr_ptr), 32'd0);
        chk("reset.wrapped", 32'(o_wrapped), 32'd0);
        chk("reset.full", 32'(o_full), 32'd0);
        chk("reset.rd_valid", 32'(o_rd_valid), 32'd0);
        chk("reset.rd_data", 32'(o_rd_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Circular fill and readback
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1,0,0,1,16'(16'h1000 + k),0,0, 1,0,3'((k + 1) % 8),k >= 7,0,0,16'h0000));
        tbl.push_back(mk(1,0,0,0,16'h0,1,3'd0, 1,1,3'd2,1,0,1,16'h1008));
        tbl.push_back(mk(1,0,0,0,16'h0,1,3'd1, 1,1,3'd2,1,0,1,16'h1009));
        tbl.push_back(mk(1,0,0,0,16'h0,1,3'd7, 1,1,3'd2,1,0,1,16'h1007));
        tbl.push_back(mk(0,0,0,0,16'h0,0,3'd0, 0,0,3'd2,1,0,0,16'h1007));
        // Bank conflict and parallel access
        tbl.push_back(mk(1,0,0,1,16'h2002,0,3'd0, 1,0,3'd3,1,0,0,16'h1007));
        tbl.push_back(mk(1,0,0,1,16'h2003,0,3'd0, 1,0,3'd4,1,0,0,16'h1007));
        tbl.push_back(mk(1,0,0,1,16'h2004,1,3'd2, 1,0,3'd5,1,0,0,16'h1007));
        tbl.push_back(mk(1,0,0,1,16'h2005,1,3'd2, 1,1,3'd6,1,0,1,16'h2002));
        tbl.push_back(mk(1,0,0,1,16'h2006,1,3'd3, 1,1,3'd7,1,0,1,16'h2003));
        // Clear with valid, then clear with read
        tbl.push_back(mk(1,0,1,1,16'hDEAD,0,3'd0, 0,0,3'd0,0,0,0,16'h2003));
        tbl.push_back(mk(1,0,0,0,16'h0,1,3'd7, 1,1,3'd0,0,0,1,16'h1007));
        tbl.push_back(mk(1,0,1,0,16'h0,1,3'd6, 0,1,3'd0,0,0,1,16'h2006));
        // Stop mode fill
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1,1,0,1,16'(16'h3000 + k),0,3'd0, k < 8,0,
                             (k < 8) ? 3'((k + 1) % 8) : 3'd0, k >= 7,k >= 7,0,16'h2006));
        tbl.push_back(mk(1,1,0,0,16'h0,1,3'd0, 0,1,3'd0,1,1,1,16'h3000));
        // Release to circular
        tbl.push_back(mk(1,0,0,1,16'h4000,0,3'd0, 1,0,3'd1,1,1,0,16'h3000));
        tbl.push_back(mk(1,0,0,0,16'h0,1,3'd0, 1,1,3'd1,1,1,1,16'h4000));

        foreach (tbl[i]) cyc(tbl[i], 1'b1, $sformatf("row%0d", i));

        // Async reset in the cycle after a read is accepted
        cyc(mk(0,0,0,0,16'h0,1,3'd0, 0,0,3'd0,0,0,0,16'h0), 1'b0, "pre_rst");
        reset_n = 1'b0;
        #1;
        chk("arst.rd_valid", 32'(o_rd_valid), 32'd0);
        chk("arst.wr_ptr", 32'(o_wr_ptr), 32'd0);
        chk("arst.full", 32'(o_full), 32'd0);
        chk("arst.wrapped", 32'(o_wrapped), 32'd0);
        chk("arst.rd_data", 32'(o_rd_data), 32'd0);
        model_reset();
        i_rd_req = 0; i_trc_valid = 0; i_enable = 0; i_clear = 0; i_mode_stop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst.no_late_valid", 32'(o_rd_valid), 32'd0);

        // Random traffic in alternating stop/circular segments
        hold = 0; haddr = '0;
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 100; c++) begin
                v = mk(0,0,0,0,16'h0,0,3'd0, 0,0,3'd0,0,0,0,16'h0);
                v.en    = ($urandom % 8) != 0;
                v.stop  = seg[0];
                v.clr   = ($urandom % 40) == 0;
                v.valid = ($urandom % 4) != 0;
                v.d     = 16'($urandom);
                if (hold && !m_last_rf) begin
                    v.rq = 1; v.ra = haddr;
                end else if (($urandom % 3) == 0) begin
                    haddr = 3'($urandom); v.rq = 1; v.ra = haddr; hold = 1;
                end else begin
                    hold = 0;
                end
                if (hold && m_last_rf && !v.rq) hold = 0;
                cyc(v, 1'b0, $sformatf("rnd%0d_%0d", seg, c));
                if (m_last_rf) hold = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dfd_trace_mem_sink_ctrl.md
Name: dfd_trace_mem_sink_ctrl

Overview:
- Parametrised successor to the fixed-geometry trace sink.
- Owns a banked trace SRAM of NUM_BANKS x 2^INDEX_WIDTH words of DATA_WIDTH bits. Each bank is a single-port generic_mem_model.
- Accepts trace words over a valid/ready stream and writes them bank-interleaved at a hardware write pointer. Two modes: circular (wrap) and stop-on-full.
- Provides a 1-cycle-latency debug readback port that arbitrates against trace writes per bank.
- Sits between the trace encoder/funnel and the debug register interface.

Parameters:
- NUM_BANKS, 8, number of RAM banks; power of two, >= 2.
- INDEX_WIDTH, 9, address bits per bank (depth 2^INDEX_WIDTH).
- DATA_WIDTH, 64, trace word width.
- TSEL_CONFIGURABLE, 0, forwarded to every bank.
- Derived: BW = log2(NUM_BANKS); AW = BW + INDEX_WIDTH; ENTRIES = 2^AW.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  trace capture enable
- i_mode_stop  in  1  1 = stop on full, 0 = circular
- i_clear  in  1  pulse: zero the pointer and the flags
- i_trc_valid  in  1  trace word valid
- i_trc_data  in  DATA_WIDTH  trace word
- o_trc_ready  out  1  trace word accepted this cycle when valid is also high
- o_wr_ptr  out  AW  next entry to be written
- o_wrapped  out  1  sticky: pointer has wrapped at least once
- o_full  out  1  sticky: stop-mode buffer filled
- i_rd_req  in  1  readback request
- i_rd_addr  in  AW  readback entry address
- o_rd_ready  out  1  readback request accepted this cycle
- o_rd_valid  out  1  readback data valid (1-cycle pulse)
- o_rd_data  out  DATA_WIDTH  readback data
- i_mem_tsel_settings  in  11  forwarded to all banks

Behaviour:
- Reset (async assert, sync release): o_wr_ptr=0, o_wrapped=0, o_full=0, o_rd_valid=0, o_rd_data=0. o_trc_ready and o_rd_ready are combinational on inputs and state.
- Address map for both pointer and read address:
  - bank = addr[BW-1:0]
  - index = addr[AW-1:BW]
  - Consecutive trace words therefore rotate through the banks.
- o_trc_ready = i_enable & ~i_clear & ~(i_mode_stop & o_full).
- Write fires when i_trc_valid & o_trc_ready. On a write:
  - bank[o_wr_ptr bank] gets chip_en=1, wr_en=1, full write mask.
  - o_wr_ptr advances by 1, modulo ENTRIES.
- Wrap: a write at o_wr_ptr = ENTRIES-1 sets o_wr_ptr=0 and o_wrapped=1, in either mode.
  - In stop mode the same write also sets o_full=1, so o_trc_ready drops the next cycle.
- Full with mode change: if o_full=1 and i_mode_stop drops to 0, o_trc_ready reasserts. Writes resume at pointer 0. o_full stays 1 until i_clear.
- i_clear (registered effect, takes priority over everything):
  - Next cycle: o_wr_ptr=0, o_wrapped=0, o_full=0.
  - No trace write occurs in the clear cycle.
  - A readback in the clear cycle is unaffected.
- Readback arbitration:
  - o_rd_ready = i_rd_req & ~(trace write firing to the same bank this cycle).
  - Trace writes always win on a bank conflict. A read to a different bank proceeds in parallel.
  - The requester holds i_rd_req and i_rd_addr until o_rd_ready.
- Readback timing:
  - Accepted read in cycle N drives bank chip_en=1, wr_en=0 in cycle N.
  - Cycle N+1: o_rd_valid=1 and o_rd_data = that bank's output, muxed by the bank index registered in N.
  - o_rd_data holds its value until the next accepted read. o_rd_valid is high for exactly one cycle.
- Bank idle: banks with no access in a cycle have chip_en=0.
- Unused bank ports: tied as in the existing sink (rd_en, repair, wr_all = 0; DFT inputs unconnected).
- Read vs write ordering: a read of an address written in the same cycle cannot happen, because of the same-bank conflict rule. A read issued after the write returns the new data.
- i_enable=0 blocks capture only. The pointer and flags hold, and readback still works.
- Reset asserted mid-stream aborts any pending read; no o_rd_valid is produced. Memory contents are undefined after reset.

Test Plan:
Bench configuration: NUM_BANKS=2, INDEX_WIDTH=2, DATA_WIDTH=16 (ENTRIES=8).
- Circular fill: mode_stop=0, stream 0x1000..0x1009 (10 words) -> o_wr_ptr=2 and o_wrapped=1 after word 8. Readback addr 0 -> 0x1008, addr 1 -> 0x1009, addr 7 -> 0x1007. Each read shows o_rd_valid one cycle after o_rd_ready.
- Stop mode: mode_stop=1, stream 10 words with valid held -> exactly 8 accepted. o_full=1 and o_trc_ready=0 from the cycle after the 8th write; o_wr_ptr=0; addr 0 reads back 0x1000.
- Bank conflict: write to ptr 4 (bank 0) while reading addr 2 (bank 0) -> o_rd_ready=0 that cycle and accepted the next. Simultaneous read of addr 3 (bank 1) -> accepted immediately.
- Clear with valid: i_clear=1 together with i_trc_valid=1 at ptr 5 -> no write (addr 5 keeps its old value). Next cycle ptr=0, wrapped=0, full=0.
- Stop-to-circular release: from full, drop mode_stop -> o_trc_ready=1, next word lands at addr 0, o_full remains 1.
- Async reset mid-read: assert reset_n=0 in the cycle after o_rd_ready -> o_rd_valid=0 and o_wr_ptr=0 immediately, not waiting for a clock edge.
